// File: rtl/dsp_config_loader.sv
// Serial configuration loader: accepts WORD_W-bit words over valid/ready and
// shifts the CHAIN_LEN-bit frame LSB-first into the DSP slice configuration chain.
module dsp_config_loader #(
  parameter int unsigned CHAIN_LEN = 13,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              configuration_input,
  output logic              configuration_enable,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WL_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t            state, state_next;
  logic [WORD_W-1:0] sreg, sreg_next;
  logic [CNT_W-1:0]  frame_cnt, frame_cnt_next, frame_cnt_inc;
  logic [WL_W-1:0]   word_left, word_left_next;
  logic              cfg_in_q, cfg_en_q;

  // Bits to take from a freshly captured word: the last word may be partial.
  function automatic logic [WL_W-1:0] word_len(input logic [CNT_W-1:0] consumed);
    logic [CNT_W-1:0] remaining;
    remaining = CNT_W'(CHAIN_LEN) - consumed;
    if (remaining >= CNT_W'(WORD_W)) return WL_W'(WORD_W);
    return WL_W'(remaining);
  endfunction

  assign frame_cnt_inc = frame_cnt + CNT_W'(1);

  always_comb begin
    state_next     = state;
    sreg_next      = sreg;
    frame_cnt_next = frame_cnt;
    word_left_next = word_left;
    cfg_ready      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          frame_cnt_next = '0;
          state_next     = LOAD;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          sreg_next      = cfg_data;
          word_left_next = word_len(frame_cnt);
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        sreg_next      = sreg >> 1;
        word_left_next = word_left - WL_W'(1);
        frame_cnt_next = frame_cnt_inc;
        if (word_left == WL_W'(1)) begin
          if (frame_cnt_inc == CNT_W'(CHAIN_LEN)) begin
            state_next = DONE;
          end else begin
            // Accepting the next word on the last bit avoids a bubble.
            cfg_ready = 1'b1;
            if (cfg_valid) begin
              sreg_next      = cfg_data;
              word_left_next = word_len(frame_cnt_inc);
            end else begin
              state_next = LOAD;
            end
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Chain outputs are registered from next-state values so they line up with SHIFT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      frame_cnt <= '0;
      word_left <= '0;
      cfg_in_q  <= 1'b0;
      cfg_en_q  <= 1'b0;
    end else begin
      state     <= state_next;
      sreg      <= sreg_next;
      frame_cnt <= frame_cnt_next;
      word_left <= word_left_next;
      cfg_en_q  <= (state_next == SHIFT);
      cfg_in_q  <= (state_next == SHIFT) && sreg_next[0];
    end
  end

  assign configuration_input  = cfg_in_q;
  assign configuration_enable = cfg_en_q;
  assign busy                 = (state != IDLE);
  assign done                 = (state == DONE);

endmodule

// File: tb/tb_dsp_config_loader.sv
// Directed bench for dsp_config_loader: timing masks per cycle, serial content,
// gaps, mid-frame reset, ignored inputs, edge sizes and a 13-block chain model.
module tb_dsp_config_loader;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] data;
  logic       valid;
  logic [1:0] sel;

  logic [2:0] ready_v, cin_v, cen_v, busy_v, done_v;
  logic       cur_ready, cur_cin, cur_cen, cur_busy, cur_done;

  int compared;
  int mismatched;

  logic [31:0] en_m, rdy_m, dn_m, bsy_m;
  logic [15:0] seq;
  int          nbits;
  int          words;
  logic [1:0]  pre_rst;
  logic [4:0]  rst_snap;

  logic [12:0] chain;
  string blk [13] = '{"a_reg", "b_reg", "c_reg", "d_reg", "xyzw", "carry_in", "operation",
                      "inmode", "multmode", "mult_out", "pattern_det", "wide_xor", "output_mgr"};

  dsp_config_loader #(.CHAIN_LEN(13), .WORD_W(8), .CNT_W(16)) dut_n13 (
    .clk(clk), .reset_n(reset_n), .start(start && (sel == 2'd0)), .cfg_data(data),
    .cfg_valid(valid && (sel == 2'd0)), .cfg_ready(ready_v[0]), .configuration_input(cin_v[0]),
    .configuration_enable(cen_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  dsp_config_loader #(.CHAIN_LEN(1), .WORD_W(8), .CNT_W(16)) dut_n1 (
    .clk(clk), .reset_n(reset_n), .start(start && (sel == 2'd1)), .cfg_data(data),
    .cfg_valid(valid && (sel == 2'd1)), .cfg_ready(ready_v[1]), .configuration_input(cin_v[1]),
    .configuration_enable(cen_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  dsp_config_loader #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(16)) dut_n16 (
    .clk(clk), .reset_n(reset_n), .start(start && (sel == 2'd2)), .cfg_data(data),
    .cfg_valid(valid && (sel == 2'd2)), .cfg_ready(ready_v[2]), .configuration_input(cin_v[2]),
    .configuration_enable(cen_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  assign cur_ready = ready_v[sel];
  assign cur_cin   = cin_v[sel];
  assign cur_cen   = cen_v[sel];
  assign cur_busy  = busy_v[sel];
  assign cur_done  = done_v[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model: chain[0] is the head (A block), chain[12] the output manager.
  always @(posedge clk) begin
    if (cen_v[0]) chain <= {chain[11:0], cin_v[0]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_chain(input string tag, input logic [12:0] frame);
    for (int p = 0; p < 13; p++) check({tag, ".", blk[p]}, 32'(chain[p]), 32'(frame[12-p]));
  endtask

  // One cycle per iteration, starting #1 after a rising edge; start pulses at cycle 0.
  task automatic run_frame(input int n_cyc, input logic [7:0] w0, input logic [7:0] w1,
                           input int gap_until, input int start_extra, input int rst_cyc);
    words = 0; nbits = 0;
    en_m = '0; rdy_m = '0; dn_m = '0; bsy_m = '0; seq = '0;
    for (int c = 0; c < n_cyc; c++) begin
      start = (c == 0) || (c == start_extra);
      valid = (words == 0) || (c >= gap_until);
      data  = (words == 0) ? w0 : (words == 1) ? w1 : 8'hFF;
      if (c == rst_cyc) begin
        pre_rst  = {cur_busy, cur_cen};
        reset_n  = 1'b0;
        #1;
        rst_snap = {cur_ready, cur_cin, cur_cen, cur_busy, cur_done};
        break;
      end
      en_m[c[4:0]]  = cur_cen;
      rdy_m[c[4:0]] = cur_ready;
      dn_m[c[4:0]]  = cur_done;
      bsy_m[c[4:0]] = cur_busy;
      if (cur_cen) begin
        if (nbits < 16) seq[nbits[3:0]] = cur_cin;
        nbits++;
      end
      if (valid && cur_ready) words++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [31:0] en_e, input logic [31:0] rdy_e,
                           input logic [31:0] dn_e, input logic [31:0] bsy_e,
                           input logic [15:0] seq_e, input int words_e);
    check({tag, ".enable"}, en_m, en_e);
    check({tag, ".ready"}, rdy_m, rdy_e);
    check({tag, ".done"}, dn_m, dn_e);
    check({tag, ".busy"}, bsy_m, bsy_e);
    check({tag, ".serial"}, 32'(seq), 32'(seq_e));
    check({tag, ".words"}, 32'(words), 32'(words_e));
  endtask

  initial begin
    compared = 0; mismatched = 0;
    reset_n = 1'b0; start = 1'b0; data = '0; valid = 1'b0; sel = 2'd0;
    chain = '0;
    #3;
    check("reset_outputs", 32'({ready_v, cin_v, cen_v, busy_v, done_v}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back frame, valid high from IDLE, extra start pulse during SHIFT.
    run_frame(20, 8'hA5, 8'h1F, 0, 5, -1);
    check_run("b2b", 32'h0000_7FFC, 32'h0000_0202, 32'h0000_8000, 32'h0000_FFFE, 16'h1FA5, 2);
    check_chain("chain_b2b", 13'h1FA5);

    // Second word withheld until cycle 13; high bits of the last word discarded.
    run_frame(22, 8'h3C, 8'hEA, 13, 11, -1);
    check_run("gap", 32'h0007_C3FC, 32'h0000_3E02, 32'h0008_0000, 32'h000F_FFFE, 16'h0A3C, 2);
    check_chain("chain_gap", 13'h0A3C);

    // Asynchronous reset in the middle of the first word.
    run_frame(20, 8'hA5, 8'h1F, 0, -1, 6);
    check("rst_pre_busy_en", 32'(pre_rst), 32'h3);
    check("rst_outputs_now", 32'(rst_snap), 32'h0);
    @(posedge clk); #1;
    check("rst_outputs_held", 32'({ready_v, cin_v, cen_v, busy_v, done_v}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_frame(20, 8'h3C, 8'h15, 0, -1, -1);
    check_run("post_rst", 32'h0000_7FFC, 32'h0000_0202, 32'h0000_8000, 32'h0000_FFFE, 16'h153C, 1 + 1);
    check_chain("chain_post_rst", 13'h153C);

    // N=1: single enabled cycle carrying bit 0 of 0xFE.
    sel = 2'd1;
    run_frame(6, 8'hFE, 8'h00, 0, -1, -1);
    check_run("n1", 32'h0000_0004, 32'h0000_0002, 32'h0000_0008, 32'h0000_000E, 16'h0000, 1);

    // N=16: two full words, no bubble between them.
    sel = 2'd2;
    run_frame(21, 8'h5A, 8'hC3, 0, -1, -1);
    check_run("n16", 32'h0003_FFFC, 32'h0000_0202, 32'h0004_0000, 32'h0007_FFFE, 16'hC35A, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
